nanov_digit_exec: RTL

Digit-serial integer execution unit for the nanoV family. It generalises the bit-serial ALU/shifter datapath to a configurable digit width and a configurable word width. Operands stream in LSB-first, DIGIT_BITS per accepted step, and input stalls are supported. Shifts and set-less-than use an internal word buffer and a second emit phase. It sits between the register-file read ports and the rd write port, and its compare flags feed branch resolution.

---
 rtl/nanov_digit_exec.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/nanov_digit_exec.sv
// nanov_digit_exec: digit-serial ALU / shifter / comparator, operands streamed LSB-first.
// Define NANOV_EXEC_ROT_EN to build ROL (op 1001) and ROR (op 1011).
module nanov_digit_exec #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DIGIT_BITS = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [3:0]              op,
   input  logic [$clog2(XLEN)-1:0] shamt,
   output logic                    ready,
   input  logic                    in_valid,
   input  logic [DIGIT_BITS-1:0]   a_in,
   input  logic [DIGIT_BITS-1:0]   b_in,
   output logic                    res_valid,
   output logic [DIGIT_BITS-1:0]   res_out,
   output logic                    res_last,
   output logic                    cmp_eq,
   output logic                    cmp_lt,
   output logic                    cmp_ltu
);

   localparam int unsigned DIGITS   = XLEN / DIGIT_BITS;
   localparam int unsigned SW       = $clog2(XLEN);
   localparam int unsigned CW       = ($clog2(DIGITS) > 5) ? $clog2(DIGITS) : 5;
   localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

   if ((XLEN & (XLEN - 1)) != 0) begin : g_bad_xlen
      $error("nanov_digit_exec: XLEN must be a power of two");
   end
   if (DIGIT_BITS != 1 && DIGIT_BITS != 2 && DIGIT_BITS != 4 && DIGIT_BITS != 8) begin : g_bad_digit
      $error("nanov_digit_exec: DIGIT_BITS must be 1, 2, 4 or 8");
   end
   if ((XLEN % DIGIT_BITS) != 0) begin : g_bad_div
      $error("nanov_digit_exec: DIGIT_BITS must divide XLEN");
   end

   typedef enum logic [1:0] {IDLE, STREAM, LOAD, EMIT} state_e;
   typedef enum logic [2:0] {SEL_SLL, SEL_SRL, SEL_SRA, SEL_SLT, SEL_SLTU, SEL_ROL, SEL_ROR} sel_e;

   state_e                            state, state_nxt;
   logic   [3:0]                      op_q;
   sel_e                              sel_q, op_sel;
   logic                              op_is_load;
   logic   [SW-1:0]                   shamt_q;
   logic   [CW-1:0]                   cnt;
   logic                              alu_carry, cmp_carry, eq_acc;
   logic   [DIGIT_BITS-1:0]           res_q;
   logic                              stream_valid_q, stream_last_q;
   logic   [XLEN-1:0]                 word_buf;

   logic                              accept, at_last, first_digit;
   logic                              alu_sub, alu_cin, eq_in;
   logic   [DIGIT_BITS-1:0]           b_eff, alu_digit;
   logic   [DIGIT_BITS:0]             alu_sum, cmp_sum;
   logic   [XLEN-1:0]                 res_word;
   logic   [DIGITS-1:0][DIGIT_BITS-1:0] res_digits;
   logic   [DIGIT_BITS-1:0]           emit_digit;

   assign accept      = in_valid && (state == STREAM || state == LOAD);
   assign at_last     = (cnt == LAST_IDX);
   assign first_digit = (cnt == '0);

   // Operation decode, applied only when a start is accepted
   always_comb begin
      op_is_load = 1'b0;
      op_sel     = SEL_SLL;
      case (op[2:0])
         3'b001: begin
            op_is_load = 1'b1;
            op_sel     = SEL_SLL;
`ifdef NANOV_EXEC_ROT_EN
            if (op[3]) op_sel = SEL_ROL;
`endif
         end
         3'b010: begin
            op_is_load = 1'b1;
            op_sel     = SEL_SLT;
         end
         3'b011: begin
            op_is_load = 1'b1;
            op_sel     = SEL_SLTU;
`ifdef NANOV_EXEC_ROT_EN
            if (op[3]) op_sel = SEL_ROR;
`endif
         end
         3'b101: begin
            op_is_load = 1'b1;
            op_sel     = op[3] ? SEL_SRA : SEL_SRL;
         end
         default: op_is_load = 1'b0;
      endcase
   end

   // Streaming ALU digit: SUB inverts B and injects carry 1 on digit 0
   always_comb begin
      alu_sub = (op_q == 4'b1000);
      b_eff   = alu_sub ? ~b_in : b_in;
      alu_cin = first_digit ? alu_sub : alu_carry;
      alu_sum = {1'b0, a_in} + {1'b0, b_eff} + {{DIGIT_BITS{1'b0}}, alu_cin};
      case (op_q[2:0])
         3'b100:  alu_digit = a_in ^ b_in;
         3'b110:  alu_digit = a_in | b_in;
         3'b111:  alu_digit = a_in & b_in;
         default: alu_digit = alu_sum[DIGIT_BITS-1:0];
      endcase
   end

   // Compare chain always forms A-B; A==B exactly when every difference digit is zero
   always_comb begin
      cmp_sum = {1'b0, a_in} + {1'b0, ~b_in} + {{DIGIT_BITS{1'b0}}, (first_digit | cmp_carry)};
      eq_in   = first_digit | eq_acc;
   end

   always_comb begin
      case (sel_q)
         SEL_SRL:  res_word = word_buf >> shamt_q;
         SEL_SRA:  res_word = $signed(word_buf) >>> shamt_q;
         SEL_SLT:  res_word = XLEN'(cmp_lt);
         SEL_SLTU: res_word = XLEN'(cmp_ltu);
`ifdef NANOV_EXEC_ROT_EN
         SEL_ROL:  res_word = (word_buf << shamt_q) | (word_buf >> (XLEN - 32'(shamt_q)));
         SEL_ROR:  res_word = (word_buf >> shamt_q) | (word_buf << (XLEN - 32'(shamt_q)));
`endif
         default:  res_word = word_buf << shamt_q;
      endcase
      res_digits = res_word;
      emit_digit = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (cnt == CW'(i)) emit_digit = res_digits[i];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = op_is_load ? LOAD : STREAM;
         STREAM:  if (accept && at_last) state_nxt = IDLE;
         LOAD:    if (accept && at_last) state_nxt = EMIT;
         EMIT:    if (at_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready     = (state == IDLE);
      res_valid = stream_valid_q;
      res_last  = stream_last_q;
      res_out   = res_q;
      if (state == EMIT) begin
         res_valid = 1'b1;
         res_last  = at_last;
         res_out   = emit_digit;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_q           <= '0;
         sel_q          <= SEL_SLL;
         shamt_q        <= '0;
         cnt            <= '0;
         alu_carry      <= 1'b0;
         cmp_carry      <= 1'b0;
         eq_acc         <= 1'b0;
         res_q          <= '0;
         stream_valid_q <= 1'b0;
         stream_last_q  <= 1'b0;
         word_buf       <= '0;
         cmp_eq         <= 1'b0;
         cmp_lt         <= 1'b0;
         cmp_ltu        <= 1'b0;
      end else begin
         stream_valid_q <= 1'b0;
         stream_last_q  <= 1'b0;
         if (state == IDLE && start) begin
            op_q    <= op;
            sel_q   <= op_sel;
            shamt_q <= shamt;
            cnt     <= '0;
            cmp_eq  <= 1'b0;
            cmp_lt  <= 1'b0;
            cmp_ltu <= 1'b0;
         end
         if (accept) begin
            cnt       <= at_last ? '0 : cnt + 1'b1;
            alu_carry <= alu_sum[DIGIT_BITS];
            cmp_carry <= cmp_sum[DIGIT_BITS];
            eq_acc    <= eq_in & (cmp_sum[DIGIT_BITS-1:0] == '0);
            if (at_last) begin
               cmp_eq  <= eq_in & (cmp_sum[DIGIT_BITS-1:0] == '0);
               cmp_ltu <= ~cmp_sum[DIGIT_BITS];
               cmp_lt  <= (a_in[DIGIT_BITS-1] != b_in[DIGIT_BITS-1]) ? a_in[DIGIT_BITS-1]
                                                                      : cmp_sum[DIGIT_BITS-1];
            end
            if (state == STREAM) begin
               res_q          <= alu_digit;
               stream_valid_q <= 1'b1;
               stream_last_q  <= at_last;
            end else begin
               word_buf <= (word_buf >> DIGIT_BITS) | (XLEN'(a_in) << (XLEN - DIGIT_BITS));
            end
         end
         if (state == EMIT) cnt <= at_last ? '0 : cnt + 1'b1;
      end
   end

endmodule
